ex_stage: RTL

Execute stage of the five-stage pipeline. It consumes the operands and decoded operation held in the ID/EX pipeline register and computes the write-back value, which goes to the EX/MEM register. Logic, shift and add/compare operations are single-cycle and combinational. DIV/DIVU use an iterative 32-step radix-2 divider that stalls the pipeline through `stallreq_o` until HI/LO results are ready.

---
 rtl/ex_stage.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage of the five-stage pipeline.
// Single-cycle logic / shift / add-compare operations feed wdata_o directly.
// Build option EX_DIV_EN: when defined, DIV/DIVU run on an iterative 32-step
// restoring divider that holds the pipeline through stallreq_o until HI/LO
// are ready. When undefined, DIV/DIVU are treated as no-ops.
module ex_stage #(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o
);

  // Operation codes and result classes shared with the decode stage.
  localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
  localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
  localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
  localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
  localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
  localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
  localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
  localparam logic [7:0] EXE_SLT_OP  = 8'b00101010;
  localparam logic [7:0] EXE_SLTU_OP = 8'b00101011;
  localparam logic [7:0] EXE_ADDU_OP = 8'b00100001;
  localparam logic [7:0] EXE_SUBU_OP = 8'b00100011;
  localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  logic [31:0] logic_res;
  logic [31:0] shift_res;
  logic [31:0] arith_res;
  logic [31:0] wdata_sel;
  logic        is_div;

  logic        div_stall;
  logic        div_whilo;
  logic [31:0] div_hi;
  logic [31:0] div_lo;

  assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

  // Bitwise logic results.
  always_comb begin
    logic_res = 32'd0;
    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      default:    logic_res = 32'd0;
    endcase
  end

  // Shifts of reg2 by the low five bits of reg1.
  always_comb begin
    shift_res = 32'd0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << reg1_i[4:0];
      EXE_SRL_OP: shift_res = reg2_i >> reg1_i[4:0];
      EXE_SRA_OP: shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
      default:    shift_res = 32'd0;
    endcase
  end

  // Wrap-around add/subtract and set-less-than compares.
  always_comb begin
    arith_res = 32'd0;
    case (aluop_i)
      EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
      EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
      EXE_SLTU_OP: arith_res = {31'd0, reg1_i < reg2_i};
      default:     arith_res = 32'd0;
    endcase
  end

  // Write-back mux by result class; divides never write a GPR value.
  always_comb begin
    wdata_sel = 32'd0;
    case (alusel_i)
      EXE_RES_LOGIC: wdata_sel = logic_res;
      EXE_RES_SHIFT: wdata_sel = shift_res;
      EXE_RES_ARITH: wdata_sel = arith_res;
      EXE_RES_NOP:   wdata_sel = 32'd0;
      default:       wdata_sel = 32'd0;
    endcase
    if (is_div) begin
      wdata_sel = 32'd0;
    end
  end

`ifdef EX_DIV_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STEP_W = $clog2(DIV_STEPS);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DIV_STEPS - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [31:0]       quot_reg;
  logic [31:0]       rem_reg;
  logic [31:0]       divisor_reg;
  logic [STEP_W-1:0] step_reg;
  logic              neg_q_reg;
  logic              neg_r_reg;

  logic              is_signed_div;
  logic [31:0]       abs_a;
  logic [31:0]       abs_b;
  logic [32:0]       partial;
  logic [32:0]       trial;
  logic              take;

  assign is_signed_div = (aluop_i == EXE_DIV_OP);

  // Operand magnitudes and one restoring step: shift in the next dividend
  // bit, subtract the divisor, keep the difference only if it did not borrow.
  always_comb begin
    abs_a   = (is_signed_div && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    abs_b   = (is_signed_div && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
    partial = {rem_reg, quot_reg[31]};
    trial   = partial - {1'b0, divisor_reg};
    take    = ~trial[32];
  end

  // Divider state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Divider datapath: load on entry, iterate while busy, hold through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_reg    <= 32'd0;
      rem_reg     <= 32'd0;
      divisor_reg <= 32'd0;
      step_reg    <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_div) begin
            // Quotient register starts as the dividend and is shifted out
            // MSB-first while quotient bits are shifted in at the bottom.
            quot_reg    <= (reg2_i != 32'd0) ? abs_a : 32'd0;
            rem_reg     <= 32'd0;
            divisor_reg <= abs_b;
            step_reg    <= '0;
            neg_q_reg   <= (reg2_i != 32'd0) && is_signed_div && (reg1_i[31] ^ reg2_i[31]);
            neg_r_reg   <= (reg2_i != 32'd0) && is_signed_div && reg1_i[31];
          end
        end
        BUSY: begin
          rem_reg  <= take ? trial[31:0] : partial[31:0];
          quot_reg <= {quot_reg[30:0], take};
          step_reg <= step_reg + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Divider next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (is_div) begin
          state_next = (reg2_i != 32'd0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (step_reg == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Divider outputs: stall until DONE, then present sign-corrected HI/LO.
  always_comb begin
    div_stall = 1'b0;
    div_whilo = 1'b0;
    div_hi    = 32'd0;
    div_lo    = 32'd0;
    case (state_reg)
      IDLE: div_stall = is_div;
      BUSY: div_stall = 1'b1;
      DONE: begin
        div_whilo = 1'b1;
        div_lo    = neg_q_reg ? (~quot_reg + 32'd1) : quot_reg;
        div_hi    = neg_r_reg ? (~rem_reg + 32'd1) : rem_reg;
      end
      default: begin
      end
    endcase
  end
`else
  // Without the divider there is no sequential logic; the clock and the
  // step-count parameter are intentionally left without a consumer.
  logic unused_clk;
  assign unused_clk = clk & (DIV_STEPS == 32);

  assign div_stall = 1'b0;
  assign div_whilo = 1'b0;
  assign div_hi    = 32'd0;
  assign div_lo    = 32'd0;
`endif

  // Reset forces every output to zero.
  always_comb begin
    wd_o       = rst ? 5'd0 : wd_i;
    wreg_o     = rst ? 1'b0 : wreg_i;
    wdata_o    = rst ? 32'd0 : wdata_sel;
    whilo_o    = rst ? 1'b0 : div_whilo;
    hi_o       = rst ? 32'd0 : div_hi;
    lo_o       = rst ? 32'd0 : div_lo;
    stallreq_o = rst ? 1'b0 : div_stall;
  end

endmodule
